// File: rtl/a2d_pkg.sv
// Shared types and widths for the A2D channel scanner.
package a2d_pkg;

    localparam int A2D_RES_W = 12;
    localparam int CHNL_W    = 3;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        STORE,
        GAP
    } scan_state_t;

    // Accumulator is wide enough to hold 2^avg_log2 full-scale samples.
    function automatic int acc_w(input int avg_log2);
        return A2D_RES_W + avg_log2;
    endfunction

endpackage

// File: rtl/a2d_avg_acc.sv
// Per-channel sample accumulator: sums 2^AVG_LOG2 results, exposes the
// truncated average and flags the final sample of the group.
module a2d_avg_acc
    import a2d_pkg::*;
#(
    parameter int AVG_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 add,
    input  logic [A2D_RES_W-1:0] din,
    output logic                 last,
    output logic [A2D_RES_W-1:0] avg
);

    localparam int         ACC_W    = acc_w(AVG_LOG2);
    localparam logic [4:0] CNT_LAST = 5'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [4:0]       smpl_cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc      <= '0;
            smpl_cnt <= '0;
        end else if (add) begin
            acc <= acc + ACC_W'(din);
            // The last sample leaves the count at terminal; STORE clears it.
            if (!last)
                smpl_cnt <= smpl_cnt + 5'd1;
        end
    end

    assign last = (smpl_cnt == CNT_LAST);
    assign avg  = acc[AVG_LOG2 +: A2D_RES_W];

endmodule

// File: rtl/a2d_scan_seq.sv
// Round-robin A2D channel scanner: issues conversions, averages per channel,
// keeps a result register file and flags lost conversions.
module a2d_scan_seq
    import a2d_pkg::*;
#(
    parameter int NUM_CHNL = 8,
    parameter int AVG_LOG2 = 2,
    parameter int SCAN_GAP = 1000,
    parameter int TIMEOUT  = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    output logic                 strt_cnv,
    output logic [CHNL_W-1:0]    chnnl,
    input  logic                 cnv_cmplt,
    input  logic [A2D_RES_W-1:0] res,
    input  logic [CHNL_W-1:0]    rd_chnl,
    output logic [A2D_RES_W-1:0] rd_data,
    output logic                 smpl_vld,
    output logic [CHNL_W-1:0]    smpl_chnl,
    output logic [A2D_RES_W-1:0] smpl_data,
    output logic                 scan_done,
    output logic                 timeout_err,
    input  logic                 clr_err
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W = $clog2(SCAN_GAP + 1);

    scan_state_t state, nxt_state;

    logic [CHNL_W-1:0]                      chnl_idx;
    logic [TMR_W-1:0]                       timer;
    logic [GAP_W-1:0]                       gap_cnt;
    logic                                   cmplt_q;
    logic [2**CHNL_W-1:0][A2D_RES_W-1:0]    result;
    logic [A2D_RES_W-1:0]                   avg;

    logic cmplt_rise, tmo, last_chnl, gap_done, smpl_last;
    logic acc_add, acc_clr, do_store, advance;

    assign cmplt_rise = (state == WAIT) && cnv_cmplt && !cmplt_q;
    // A completion landing on the final timer cycle still counts.
    assign tmo        = (state == WAIT) && !cmplt_rise && (timer == TMR_W'(TIMEOUT - 1));
    assign last_chnl  = (chnl_idx == CHNL_W'(NUM_CHNL - 1));
    assign gap_done   = (state == GAP) && (gap_cnt == GAP_W'(SCAN_GAP - 1));

    a2d_avg_acc #(
        .AVG_LOG2 (AVG_LOG2)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .clr  (acc_clr),
        .add  (acc_add),
        .din  (res),
        .last (smpl_last),
        .avg  (avg)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= nxt_state;
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE:  if (en) nxt_state = START;
            START: nxt_state = WAIT;
            WAIT: begin
                if (cmplt_rise)
                    nxt_state = smpl_last ? STORE : START;
                else if (tmo)
                    nxt_state = last_chnl ? GAP : START;
            end
            STORE: nxt_state = last_chnl ? GAP : START;
            GAP:   if (gap_done) nxt_state = en ? START : IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    always_comb begin
        strt_cnv = (state == START);
        acc_add  = cmplt_rise;
        do_store = (state == STORE);
        advance  = (state == STORE) || tmo;
        acc_clr  = ((state == IDLE) && en) || (gap_done && en) || (state == STORE) || tmo;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chnl_idx    <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            cmplt_q     <= 1'b0;
            result      <= '0;
            smpl_vld    <= 1'b0;
            smpl_chnl   <= '0;
            smpl_data   <= '0;
            scan_done   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cmplt_q   <= cnv_cmplt;
            smpl_vld  <= do_store;
            // Lands in the first GAP cycle, whether the last channel stored or timed out.
            scan_done <= advance && last_chnl;
            timer     <= (state == WAIT) ? timer + TMR_W'(1) : '0;
            gap_cnt   <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

            if ((nxt_state == START) && ((state == IDLE) || (state == GAP)))
                chnl_idx <= '0;
            else if (advance && !last_chnl)
                chnl_idx <= chnl_idx + CHNL_W'(1);

            if (do_store) begin
                result[chnl_idx] <= avg;
                smpl_chnl        <= chnl_idx;
                smpl_data        <= avg;
            end

            if (tmo)
                timeout_err <= 1'b1;
            else if (clr_err)
                timeout_err <= 1'b0;
        end
    end

    // chnl_idx only changes on entry to START, so it doubles as the held channel.
    assign chnnl   = chnl_idx;
    assign rd_data = (int'(rd_chnl) < NUM_CHNL) ? result[rd_chnl] : '0;

endmodule
